register_file: RTL and testbench

- Architectural register file with per-register rename tags. It is the responder end of the reorder buffer's commit/rename interface.
- Accepts commit writes and dependency (rename) updates from the reorder buffer.
- Answers the decoder's two source-operand lookups. For a busy register it issues an ROB value query and resolves the operand as either a ready value or a pending ROB id.
- Sits between the decoder, the reorder buffer and the reservation station / load-store buffer issue path.

---
 rtl/register_file.sv | 159 +++++++++++++++
 tb/tb_register_file.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : Architectural register file with per-register rename tags.
//               This block is the responder end of the reorder buffer's
//               commit/rename interface. It resolves the decoder's two
//               source operands. Each operand resolves to a final value or
//               to a pending ROB producer id.
// Ports       :
//   clk, rst (sync, active-low), rdy (global enable), clear (flush)
//   commit_*            : ROB commit of a register-writing instruction
//   dep_*               : ROB rename of a destination register
//   query_rs1/2         : decoder source registers
//   rob_query_id1/2     : ROB entries polled for busy sources
//   rob_value1/2(_ready): ROB answers to those polls
//   rs1_*/rs2_*         : resolved operand (ready, value, dep tag)
//   commit_count        : number of accepted commits (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int ROB_ID_W = 3,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                clear,
    input  logic                commit_valid,
    input  logic [4:0]          commit_rd,
    input  logic [31:0]         commit_val,
    input  logic [ROB_ID_W-1:0] commit_rob_id,
    input  logic                dep_valid,
    input  logic [4:0]          dep_rd,
    input  logic [ROB_ID_W-1:0] dep_rob_id,
    input  logic [4:0]          query_rs1,
    input  logic [4:0]          query_rs2,
    output logic [ROB_ID_W-1:0] rob_query_id1,
    output logic [ROB_ID_W-1:0] rob_query_id2,
    input  logic                rob_value1_ready,
    input  logic [31:0]         rob_value1,
    input  logic                rob_value2_ready,
    input  logic [31:0]         rob_value2,
    output logic                rs1_ready,
    output logic [31:0]         rs1_value,
    output logic [ROB_ID_W-1:0] rs1_dep,
    output logic                rs2_ready,
    output logic [31:0]         rs2_value,
    output logic [ROB_ID_W-1:0] rs2_dep,
    output logic [31:0]         commit_count
);

    // Packed lookup result: {ready, value, dep, query_id}
    localparam int c_LOOKUP_W = 1 + 32 + 2 * ROB_ID_W;

    logic [31:0]         r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [ROB_ID_W-1:0] r_tag  [NUM_REGS];
    logic [31:0]         r_commit_count;

    logic                w_commit_wr;
    logic                w_dep_wr;
    logic                w_commit_frees;
    logic [c_LOOKUP_W-1:0] w_lookup1;
    logic [c_LOOKUP_W-1:0] w_lookup2;

    assign w_commit_wr = commit_valid && (commit_rd != 5'd0);
    assign w_dep_wr    = dep_valid && (dep_rd != 5'd0);

    // A commit frees its register only if it is still the newest producer.
    // A rename of the same register in this cycle takes precedence.
    assign w_commit_frees = w_commit_wr
                         && (r_tag[commit_rd] == commit_rob_id)
                         && !(w_dep_wr && (dep_rd == commit_rd));

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_busy         <= '0;
            r_commit_count <= '0;
        end else if (rdy) begin
            // rd==0 commits are counted even though they write nothing.
            if (commit_valid) begin
                r_commit_count <= r_commit_count + 32'd1;
            end
            // The commit predates any flush in the same cycle, so its value lands.
            if (w_commit_wr) begin
                r_regs[commit_rd] <= commit_val;
            end
            if (clear) begin
                // Flush discards all renames, including one arriving now.
                r_busy <= '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_tag[i] <= '0;
                end
            end else begin
                if (w_commit_frees) begin
                    r_busy[commit_rd] <= 1'b0;
                end
                if (w_dep_wr) begin
                    r_busy[dep_rd] <= 1'b1;
                    r_tag[dep_rd]  <= dep_rob_id;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand lookup. It sees pre-rename state, so a same-cycle dep to
    // the source register does not affect the result.
    // ------------------------------------------------------------------
    function automatic logic [c_LOOKUP_W-1:0] f_lookup(
        input logic [4:0]  r,
        input logic        rv_ready,
        input logic [31:0] rv
    );
        logic                v_ready;
        logic [31:0]         v_value;
        logic [ROB_ID_W-1:0] v_dep;
        logic [ROB_ID_W-1:0] v_qid;
        v_ready = 1'b1;
        v_value = '0;
        v_dep   = '0;
        v_qid   = r_busy[r] ? r_tag[r] : '0;
        if (r == 5'd0) begin
            v_value = '0;
        end else if (!r_busy[r]) begin
            v_value = r_regs[r];
        end else if (commit_valid && (commit_rd == r) && (commit_rob_id == r_tag[r])) begin
            // Bypass of the commit that will clear this busy bit at the edge.
            v_value = commit_val;
        end else if (rv_ready) begin
            v_value = rv;
        end else begin
            v_ready = 1'b0;
            v_dep   = r_tag[r];
        end
        return {v_ready, v_value, v_dep, v_qid};
    endfunction

    always_comb begin
        w_lookup1 = f_lookup(query_rs1, rob_value1_ready, rob_value1);
    end

    always_comb begin
        w_lookup2 = f_lookup(query_rs2, rob_value2_ready, rob_value2);
    end

    assign {rs1_ready, rs1_value, rs1_dep, rob_query_id1} = w_lookup1;
    assign {rs2_ready, rs2_value, rs2_dep, rob_query_id2} = w_lookup2;
    assign commit_count = r_commit_count;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file. A behavioural model
//               tracks the architectural state and predicts the operand
//               lookup every cycle. Directed vectors carry hand-computed
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    localparam int ROB_ID_W = 3;

    logic                clk = 1'b0;
    logic                rst, rdy, clear;
    logic                commit_valid, dep_valid;
    logic [4:0]          commit_rd, dep_rd, query_rs1, query_rs2;
    logic [31:0]         commit_val, rob_value1, rob_value2;
    logic [ROB_ID_W-1:0] commit_rob_id, dep_rob_id;
    logic [ROB_ID_W-1:0] rob_query_id1, rob_query_id2, rs1_dep, rs2_dep;
    logic                rob_value1_ready, rob_value2_ready, rs1_ready, rs2_ready;
    logic [31:0]         rs1_value, rs2_value, commit_count;

    int checks   = 0;
    int failures = 0;

    register_file #(.ROB_ID_W(ROB_ID_W), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_val(commit_val), .commit_rob_id(commit_rob_id),
        .dep_valid(dep_valid), .dep_rd(dep_rd), .dep_rob_id(dep_rob_id),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rob_query_id1(rob_query_id1), .rob_query_id2(rob_query_id2),
        .rob_value1_ready(rob_value1_ready), .rob_value1(rob_value1),
        .rob_value2_ready(rob_value2_ready), .rob_value2(rob_value2),
        .rs1_ready(rs1_ready), .rs1_value(rs1_value), .rs1_dep(rs1_dep),
        .rs2_ready(rs2_ready), .rs2_value(rs2_value), .rs2_dep(rs2_dep),
        .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_regs [32];
    bit          m_busy [32];
    int          m_tag  [32];
    int          m_cnt;
    bit          m_valid = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst === 1'b0) begin
                for (int i = 0; i < 32; i++) begin
                    m_regs[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
                end
                m_cnt   = 0;
                m_valid = 1'b1;
            end else if (m_valid && rdy) begin
                int  crd, drd;
                bit  same_dep;
                crd = int'(commit_rd);
                drd = int'(dep_rd);
                same_dep = dep_valid && (drd == crd);
                if (commit_valid) m_cnt = m_cnt + 1;
                if (commit_valid && crd != 0) m_regs[crd] = int'(commit_val);
                if (clear) begin
                    for (int i = 0; i < 32; i++) begin
                        m_busy[i] = 0; m_tag[i] = 0;
                    end
                end else begin
                    if (commit_valid && crd != 0 && m_tag[crd] == int'(commit_rob_id) && !same_dep)
                        m_busy[crd] = 0;
                    if (dep_valid && drd != 0) begin
                        m_busy[drd] = 1;
                        m_tag[drd]  = int'(dep_rob_id);
                    end
                end
            end
        end
    end

    // Predicted lookup result for one source.
    task automatic predict(input int r, input bit rvr, input int rv,
                           output int e_rdy, output int e_val, output int e_dep, output int e_qid);
        e_qid = m_busy[r] ? m_tag[r] : 0;
        e_rdy = 1; e_val = 0; e_dep = 0;
        if (r == 0)                                      e_val = 0;
        else if (!m_busy[r])                             e_val = m_regs[r];
        else if (commit_valid && int'(commit_rd) == r
                 && int'(commit_rob_id) == m_tag[r])     e_val = int'(commit_val);
        else if (rvr)                                    e_val = rv;
        else begin e_rdy = 0; e_dep = m_tag[r]; end
    endtask

    // Compare DUT against the model mid-cycle, whenever outputs are meaningful.
    initial begin
        int a_r, a_v, a_d, a_q;
        forever begin
            @(negedge clk);
            #2;
            if (m_valid && clear === 1'b0) begin
                predict(int'(query_rs1), rob_value1_ready, int'(rob_value1), a_r, a_v, a_d, a_q);
                chk("model rs1_ready", 32'(rs1_ready), 32'(a_r));
                chk("model rs1_value", rs1_value, 32'(a_v));
                chk("model rs1_dep", 32'(rs1_dep), 32'(a_d));
                chk("model rob_query_id1", 32'(rob_query_id1), 32'(a_q));
                predict(int'(query_rs2), rob_value2_ready, int'(rob_value2), a_r, a_v, a_d, a_q);
                chk("model rs2_ready", 32'(rs2_ready), 32'(a_r));
                chk("model rs2_value", rs2_value, 32'(a_v));
                chk("model rs2_dep", 32'(rs2_dep), 32'(a_d));
                chk("model rob_query_id2", 32'(rob_query_id2), 32'(a_q));
                chk("model commit_count", commit_count, 32'(m_cnt));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl_idle();
        clear = 0; commit_valid = 0; dep_valid = 0;
    endtask

    task automatic do_dep(input logic [4:0] rd, input logic [ROB_ID_W-1:0] id);
        dep_valid = 1; dep_rd = rd; dep_rob_id = id;
        tick();
        dep_valid = 0;
    endtask

    task automatic set_commit(input logic [4:0] rd, input logic [ROB_ID_W-1:0] id, input logic [31:0] v);
        commit_valid = 1; commit_rd = rd; commit_rob_id = id; commit_val = v;
    endtask

    initial begin
        rst = 0; rdy = 1; ctl_idle();
        commit_rd = 0; commit_val = 0; commit_rob_id = 0;
        dep_rd = 0; dep_rob_id = 0; query_rs1 = 0; query_rs2 = 0;
        rob_value1_ready = 0; rob_value1 = 0; rob_value2_ready = 0; rob_value2 = 0;
        tick();
        rst = 1;

        // Reset state.
        query_rs1 = 5; query_rs2 = 0;
        #1;
        chk("reset rs1_ready", 32'(rs1_ready), 32'd1);
        chk("reset rs1_value", rs1_value, 32'd0);
        chk("reset rs2_ready", 32'(rs2_ready), 32'd1);
        chk("reset rs2_value", rs2_value, 32'd0);
        chk("reset commit_count", commit_count, 32'd0);
        chk("reset rob_query_id1", 32'(rob_query_id1), 32'd0);

        // Rename x5 -> rob 3, then poll the ROB.
        do_dep(5, 3);
        #1;
        chk("busy x5 rs1_ready", 32'(rs1_ready), 32'd0);
        chk("busy x5 rs1_dep", 32'(rs1_dep), 32'd3);
        chk("busy x5 rob_query_id1", 32'(rob_query_id1), 32'd3);
        @(negedge clk); #3;
        rob_value1_ready = 1; rob_value1 = 32'h1234;
        #1;
        chk("rob fwd rs1_ready", 32'(rs1_ready), 32'd1);
        chk("rob fwd rs1_value", rs1_value, 32'h1234);
        tick();
        rob_value1_ready = 0;

        // Stale commit must not free a renamed register.
        do_dep(7, 2);
        do_dep(7, 5);
        set_commit(7, 2, 32'hAA);
        tick();
        commit_valid = 0;
        query_rs2 = 7;
        #1;
        chk("stale commit rs2_ready", 32'(rs2_ready), 32'd0);
        chk("stale commit rs2_dep", 32'(rs2_dep), 32'd5);
        set_commit(7, 5, 32'hBB);
        tick();
        commit_valid = 0;
        #1;
        chk("final commit rs2_ready", 32'(rs2_ready), 32'd1);
        chk("final commit rs2_value", rs2_value, 32'hBB);

        // Same-cycle commit bypass.
        do_dep(9, 4);
        set_commit(9, 4, 32'h55);
        query_rs2 = 9;
        #1;
        chk("bypass rs2_ready", 32'(rs2_ready), 32'd1);
        chk("bypass rs2_value", rs2_value, 32'h55);
        tick();
        commit_valid = 0;

        // Commit and dep to the same register: dep keeps it busy.
        do_dep(3, 1);
        set_commit(3, 1, 32'd7);
        dep_valid = 1; dep_rd = 3; dep_rob_id = 6;
        tick();
        ctl_idle();
        query_rs1 = 3;
        #1;
        chk("dep wins rs1_ready", 32'(rs1_ready), 32'd0);
        chk("dep wins rs1_dep", 32'(rs1_dep), 32'd6);
        clear = 1;
        dep_valid = 1; dep_rd = 12; dep_rob_id = 1;   // dropped by the flush
        tick();
        ctl_idle();
        query_rs2 = 12;
        #1;
        chk("clear rs1_ready", 32'(rs1_ready), 32'd1);
        chk("clear rs1_value", rs1_value, 32'd7);
        chk("clear drops dep rs2_ready", 32'(rs2_ready), 32'd1);
        chk("count before x0 commit", commit_count, 32'd4);
        set_commit(0, 0, 32'd9);
        tick();
        commit_valid = 0;
        query_rs1 = 0;
        #1;
        chk("x0 rs1_value", rs1_value, 32'd0);
        chk("x0 commit_count", commit_count, 32'd5);

        // rdy=0 freezes state.
        do_dep(10, 2);
        rdy = 0;
        set_commit(10, 2, 32'h77);
        dep_valid = 1; dep_rd = 11; dep_rob_id = 3;
        tick();
        ctl_idle();
        rdy = 1;
        query_rs1 = 10; query_rs2 = 11;
        #1;
        chk("hold rs1_ready", 32'(rs1_ready), 32'd0);
        chk("hold rs1_dep", 32'(rs1_dep), 32'd2);
        chk("hold rs2_ready", 32'(rs2_ready), 32'd1);
        chk("hold commit_count", commit_count, 32'd5);

        // Mid-stream reset with pending busy bits; it overrides a commit.
        rst = 0;
        set_commit(10, 2, 32'h99);
        tick();
        ctl_idle();
        rst = 1;
        #1;
        chk("rst2 rs1_ready", 32'(rs1_ready), 32'd1);
        chk("rst2 rs1_value", rs1_value, 32'd0);
        chk("rst2 rob_query_id1", 32'(rob_query_id1), 32'd0);
        chk("rst2 commit_count", commit_count, 32'd0);
        query_rs1 = 7;
        #1;
        chk("rst2 x7 value", rs1_value, 32'd0);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
